mem_stage: RTL and testbench

Pipeline MEM stage directly downstream of the execute stage. Each cycle it takes the execute result: non-memory ops are registered through to writeback unchanged, while loads and stores are broken into single-byte transactions to the byte-wide memory controller. Loads are reassembled little-endian and sign- or zero-extended. `stall_req_o` freezes upstream stages until the access completes.

---
 rtl/mem_stage.sv | 145 ++++++++++++++
 tb/tb_mem_stage.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MEM stage: splits loads/stores into byte transactions; 1-cycle pass-through, N+2 for memory ops, stall_req_o holds upstream.
// Optional MEM_ALIGN_CHECK_EN rejects misaligned half/word accesses with a one-cycle misalign_o pulse.
module mem_stage #(
  parameter int                  ADDR_WIDTH         = 32,
  parameter int                  ALUSEL_W           = 3,
  parameter logic [ALUSEL_W-1:0] EXE_RES_LOAD_STORE = 3'b111
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4:0]            rd_i,
  input  logic                  wreg_i,
  input  logic [31:0]           wdata_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr_i,
  input  logic [ALUSEL_W-1:0]   alusel_i,
  input  logic [1:0]            mem_sel_i,
  input  logic                  mem_we_i,
  input  logic                  load_sign_i,
  input  logic [31:0]           reg2_i,
  input  logic                  mc_ack_i,
  input  logic [7:0]            mc_rdata_i,
  output logic                  mc_req_o,
  output logic                  mc_we_o,
  output logic [ADDR_WIDTH-1:0] mc_addr_o,
  output logic [7:0]            mc_wdata_o,
  output logic [4:0]            rd_o,
  output logic                  wreg_o,
  output logic [31:0]           wdata_o,
  output logic                  stall_req_o,
  output logic                  misalign_o
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_k;
  logic [1:0]  r_last;
  logic [31:0] r_buf;
  logic        r_misalign;
  logic        w_is_mem;
  logic        w_misalign;
  logic        w_last_ack;
  logic [1:0]  w_last_nxt;
  logic [31:0] w_ld_data;

  assign w_is_mem   = (alusel_i == EXE_RES_LOAD_STORE);
  assign w_last_nxt = (mem_sel_i == 2'd0) ? 2'd0 : (mem_sel_i == 2'd1) ? 2'd1 : 2'd3;
  assign w_last_ack = (r_state == S_ACCESS) && mc_ack_i && (r_k == r_last);

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misalign = ((mem_sel_i == 2'd1) && mem_addr_i[0]) ||
                      (mem_sel_i[1] && (mem_addr_i[1:0] != 2'b00));
  assign misalign_o = r_misalign;
`else
  assign w_misalign = 1'b0;
  assign misalign_o = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    stall_req_o = 1'b0;
    mc_req_o    = 1'b0;
    mc_we_o     = 1'b0;
    mc_addr_o   = '0;
    mc_wdata_o  = '0;
    case (r_state)
      S_IDLE: begin
        if (w_is_mem) begin
          // Gated by rst so every output reads zero while reset is held.
          stall_req_o = rst;
          w_state_nxt = w_misalign ? S_DONE : S_ACCESS;
        end
      end
      S_ACCESS: begin
        stall_req_o = 1'b1;
        mc_req_o    = 1'b1;
        mc_we_o     = mem_we_i;
        mc_addr_o   = mem_addr_i + ADDR_WIDTH'(r_k);
        mc_wdata_o  = reg2_i[{r_k, 3'b000} +: 8];
        if (w_last_ack) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_ld_data = r_buf;
    case (r_last)
      2'd0:    w_ld_data = {{24{load_sign_i & r_buf[7]}},  r_buf[7:0]};
      2'd1:    w_ld_data = {{16{load_sign_i & r_buf[15]}}, r_buf[15:0]};
      default: w_ld_data = r_buf;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_k        <= 2'd0;
      r_last     <= 2'd0;
      r_buf      <= 32'd0;
      r_misalign <= 1'b0;
      rd_o       <= 5'd0;
      wreg_o     <= 1'b0;
      wdata_o    <= 32'd0;
    end else begin
      r_misalign <= 1'b0;
      case (r_state)
        S_IDLE: begin
          rd_o    <= rd_i;
          wdata_o <= wdata_i;
          wreg_o  <= wreg_i & ~w_is_mem;
          if (w_is_mem) begin
            r_k        <= 2'd0;
            r_last     <= w_last_nxt;
            r_misalign <= w_misalign;
          end
        end
        S_ACCESS: begin
          if (mc_ack_i) begin
            if (!mem_we_i) r_buf[{r_k, 3'b000} +: 8] <= mc_rdata_i;
            r_k <= r_k + 2'd1;
          end
        end
        S_DONE: begin
          rd_o <= rd_i;
          // Stores and rejected accesses retire without a register write.
          if (mem_we_i || r_misalign) begin
            wreg_o  <= 1'b0;
            wdata_o <= 32'd0;
          end else begin
            wreg_o  <= wreg_i;
            wdata_o <= w_ld_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: stimulus pushes expected writeback/byte transactions, a monitor pops and compares.
module tb_mem_stage;
  localparam logic [2:0] LS  = 3'b111;
  localparam logic [2:0] ALU = 3'b001;

  logic        clk, rst;
  logic [4:0]  rd_i;
  logic        wreg_i;
  logic [31:0] wdata_i;
  logic [31:0] mem_addr_i;
  logic [2:0]  alusel_i;
  logic [1:0]  mem_sel_i;
  logic        mem_we_i, load_sign_i;
  logic [31:0] reg2_i;
  logic        mc_ack_i;
  logic [7:0]  mc_rdata_i;
  logic        mc_req_o, mc_we_o;
  logic [31:0] mc_addr_o;
  logic [7:0]  mc_wdata_o;
  logic [4:0]  rd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stall_req_o, misalign_o;

  mem_stage #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .rd_i(rd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .mem_addr_i(mem_addr_i), .alusel_i(alusel_i), .mem_sel_i(mem_sel_i),
    .mem_we_i(mem_we_i), .load_sign_i(load_sign_i), .reg2_i(reg2_i),
    .mc_ack_i(mc_ack_i), .mc_rdata_i(mc_rdata_i), .mc_req_o(mc_req_o),
    .mc_we_o(mc_we_o), .mc_addr_o(mc_addr_o), .mc_wdata_o(mc_wdata_o),
    .rd_o(rd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .stall_req_o(stall_req_o), .misalign_o(misalign_o)
  );

  typedef struct packed { logic [4:0] rd; logic wreg; logic [31:0] wd; } wb_t;
  typedef struct packed { logic we; logic [31:0] addr; logic [7:0] wd; } mc_t;

  wb_t         wb_q[$];
  mc_t         mc_q[$];
  int          total = 0;
  int          bad = 0;
  logic        up_vld = 1'b0;
  logic        spurious = 1'b0;
  int          ack_dly = 0;
  int          wcnt = 0;
  logic [7:0]  mem [int unsigned];

  logic        wb_pend = 1'b0;
  logic        p_req = 1'b0;
  logic        p_ack = 1'b0;
  mc_t         p_mc = '0;
  mc_t         cur;
  mc_t         emc;
  wb_t         ewb;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s actual=event required=none", nm);
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Byte-wide memory controller model with programmable ack delay.
  initial begin
    mc_ack_i   = 1'b0;
    mc_rdata_i = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (mc_req_o) begin
        if (wcnt >= ack_dly) begin
          mc_ack_i   = 1'b1;
          mc_rdata_i = mem.exists(mc_addr_o) ? mem[mc_addr_o] : 8'h00;
          wcnt       = 0;
        end else begin
          mc_ack_i = 1'b0;
          wcnt++;
        end
      end else begin
        mc_ack_i   = spurious;
        mc_rdata_i = 8'h5A;
        wcnt       = 0;
      end
    end
  end

  // Monitor: writeback compared the cycle after a committing edge; byte transfers on req&ack.
  initial begin
    forever begin
      @(negedge clk);
      cur = {mc_we_o, mc_addr_o, mc_wdata_o};
      if (wb_pend) begin
        if (wb_q.size() == 0) fail("wb_unexpected");
        else begin
          ewb = wb_q.pop_front();
          check("wb_rd", 64'(rd_o), 64'(ewb.rd));
          check("wb_wreg", 64'(wreg_o), 64'(ewb.wreg));
          check("wb_wdata", 64'(wdata_o), 64'(ewb.wd));
        end
      end
      if (mc_req_o && p_req && !p_ack) check("mc_hold", 64'(cur), 64'(p_mc));
      if (mc_req_o && mc_ack_i) begin
        if (mc_q.size() == 0) fail("mc_unexpected");
        else begin
          emc = mc_q.pop_front();
          check("mc_xfer", 64'(cur), 64'(emc));
        end
      end
      wb_pend = up_vld && !stall_req_o && rst;
      p_req   = mc_req_o;
      p_ack   = mc_ack_i;
      p_mc    = cur;
    end
  end

  task automatic issue(input string nm, input logic [4:0] rd, input logic wreg, input logic [31:0] wd,
                       input logic mem_op, input logic [31:0] addr, input logic [1:0] sel,
                       input logic we, input logic sgn, input logic [31:0] r2, input int dly,
                       input logic [31:0] exp_wd, input logic exp_wreg, input int exp_stall,
                       input logic exp_mis);
    int   n, st;
    logic mis, done;
    wb_t  w;
    mc_t  m;
    w.rd = rd; w.wreg = exp_wreg; w.wd = exp_wd;
    wb_q.push_back(w);
    n = (sel == 2'd0) ? 1 : (sel == 2'd1) ? 2 : 4;
    if (mem_op && !exp_mis) begin
      for (int i = 0; i < n; i++) begin
        m.we = we; m.addr = addr + 32'(i); m.wd = r2[8*i +: 8];
        mc_q.push_back(m);
      end
    end
    rd_i = rd; wreg_i = wreg; wdata_i = wd; alusel_i = mem_op ? LS : ALU;
    mem_addr_i = addr; mem_sel_i = sel; mem_we_i = we; load_sign_i = sgn; reg2_i = r2;
    ack_dly = dly;
    up_vld = 1'b1;
    st = 0; mis = 1'b0; done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      if (misalign_o) mis = 1'b1;
      if (!stall_req_o) done = 1'b1;
      else begin
        st++;
        @(posedge clk);
      end
    end
    if (!done) fail({nm, "_timeout"});
    check({nm, "_stall"}, 64'(st), 64'(exp_stall));
    check({nm, "_misalign"}, 64'(mis), 64'(exp_mis));
    @(posedge clk);
    #1;
    up_vld = 1'b0; alusel_i = ALU; wreg_i = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    rd_i = '0; wreg_i = 1'b0; wdata_i = '0; mem_addr_i = '0; alusel_i = '0;
    mem_sel_i = '0; mem_we_i = 1'b0; load_sign_i = 1'b0; reg2_i = '0;
    mem[32'h1000] = 8'h78; mem[32'h1001] = 8'h56; mem[32'h1002] = 8'h34; mem[32'h1003] = 8'h12;
    mem[32'h1004] = 8'hAB; mem[32'h1005] = 8'hCD;
    mem[32'h3000] = 8'h80; mem[32'h3010] = 8'h34; mem[32'h3011] = 8'h92;

    repeat (3) @(posedge clk);
    #1;
    check("rst_mc_req", 64'(mc_req_o), 64'd0);
    check("rst_stall", 64'(stall_req_o), 64'd0);
    check("rst_rd", 64'(rd_o), 64'd0);
    check("rst_wreg", 64'(wreg_o), 64'd0);
    check("rst_wdata", 64'(wdata_o), 64'd0);
    check("rst_misalign", 64'(misalign_o), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    issue("alu", 5'd5, 1'b1, 32'h12345678, 1'b0, 32'h0, 2'd0, 1'b0, 1'b0, 32'h0, 0, 32'h12345678, 1'b1, 0, 1'b0);
    spurious = 1'b1;
    issue("alu_spur", 5'd7, 1'b1, 32'hCAFEF00D, 1'b0, 32'h0, 2'd0, 1'b0, 1'b0, 32'h0, 0, 32'hCAFEF00D, 1'b1, 0, 1'b0);
    spurious = 1'b0;
    issue("lw", 5'd3, 1'b1, 32'h0, 1'b1, 32'h1000, 2'd2, 1'b0, 1'b0, 32'h0, 0, 32'h12345678, 1'b1, 5, 1'b0);
    issue("lb_s", 5'd4, 1'b1, 32'h0, 1'b1, 32'h3000, 2'd0, 1'b0, 1'b1, 32'h0, 0, 32'hFFFFFF80, 1'b1, 2, 1'b0);
    issue("lb_u", 5'd4, 1'b1, 32'h0, 1'b1, 32'h3000, 2'd0, 1'b0, 1'b0, 32'h0, 0, 32'h00000080, 1'b1, 2, 1'b0);
    issue("lh_s", 5'd6, 1'b1, 32'h0, 1'b1, 32'h3010, 2'd1, 1'b0, 1'b1, 32'h0, 0, 32'hFFFF9234, 1'b1, 3, 1'b0);
    issue("sh", 5'd8, 1'b1, 32'h0, 1'b1, 32'h2000, 2'd1, 1'b1, 1'b0, 32'hAABBCCDD, 3, 32'h0, 1'b0, 9, 1'b0);
    issue("sw", 5'd9, 1'b1, 32'h0, 1'b1, 32'h4000, 2'd2, 1'b1, 1'b0, 32'h11223344, 1, 32'h0, 1'b0, 9, 1'b0);
    issue("alu2", 5'd10, 1'b1, 32'h0BADC0DE, 1'b0, 32'h0, 2'd0, 1'b0, 1'b0, 32'h0, 0, 32'h0BADC0DE, 1'b1, 0, 1'b0);

    // Reset in the middle of a word load, after two bytes have been acknowledged.
    rd_i = 5'd9; wreg_i = 1'b1; wdata_i = 32'hDEADBEEF; alusel_i = LS; mem_addr_i = 32'h1000;
    mem_sel_i = 2'd2; mem_we_i = 1'b0; load_sign_i = 1'b0; reg2_i = 32'h55667788; ack_dly = 0;
    mc_q.push_back({1'b0, 32'h1000, 8'h88});
    mc_q.push_back({1'b0, 32'h1001, 8'h77});
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_mc_req", 64'(mc_req_o), 64'd0);
    check("mid_rst_mc_addr", 64'(mc_addr_o), 64'd0);
    check("mid_rst_mc_wdata", 64'(mc_wdata_o), 64'd0);
    check("mid_rst_stall", 64'(stall_req_o), 64'd0);
    check("mid_rst_rd", 64'(rd_o), 64'd0);
    check("mid_rst_wreg", 64'(wreg_o), 64'd0);
    check("mid_rst_wdata", 64'(wdata_o), 64'd0);
    alusel_i = ALU; wreg_i = 1'b0; rd_i = 5'd0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    issue("lb_post", 5'd11, 1'b1, 32'h0, 1'b1, 32'h1003, 2'd0, 1'b0, 1'b1, 32'h0, 0, 32'h00000012, 1'b1, 2, 1'b0);
`ifdef MEM_ALIGN_CHECK_EN
    issue("lw_mis", 5'd12, 1'b1, 32'h0, 1'b1, 32'h1002, 2'd2, 1'b0, 1'b0, 32'h0, 0, 32'h0, 1'b0, 1, 1'b1);
`else
    issue("lw_mis", 5'd12, 1'b1, 32'h0, 1'b1, 32'h1002, 2'd2, 1'b0, 1'b0, 32'h0, 0, 32'hCDAB1234, 1'b1, 5, 1'b0);
`endif

    repeat (4) @(posedge clk);
    check("wb_q_left", 64'(wb_q.size()), 64'd0);
    check("mc_q_left", 64'(mc_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
